// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures pulse high time and rising-to-rising period in clk_en ticks,
// decodes the pulse width into a direction code and reports loss of signal.
module servo_pwm_decoder #(
  parameter int CNT_BITS = 16,
  parameter int CW_LO    = 90,
  parameter int CW_HI    = 110,
  parameter int STOP_LO  = 140,
  parameter int STOP_HI  = 160,
  parameter int CCW_LO   = 190,
  parameter int CCW_HI   = 210,
  parameter int PER_LO   = 1900,
  parameter int PER_HI   = 2100,
  parameter int TIMEOUT  = 4000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                in,
  output logic [1:0]          dir,
  output logic [CNT_BITS-1:0] on_time,
  output logic [CNT_BITS-1:0] period,
  output logic                valid,
  output logic                lost
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [1:0] DIR_STOP    = 2'b00;
  localparam logic [1:0] DIR_CW      = 2'b01;
  localparam logic [1:0] DIR_CCW     = 2'b10;
  localparam logic [1:0] DIR_INVALID = 2'b11;

  localparam logic [CNT_BITS-1:0] CNT_MAX   = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT);
  localparam logic [CNT_BITS-1:0] CW_LO_C   = CNT_BITS'(CW_LO);
  localparam logic [CNT_BITS-1:0] CW_HI_C   = CNT_BITS'(CW_HI);
  localparam logic [CNT_BITS-1:0] STOP_LO_C = CNT_BITS'(STOP_LO);
  localparam logic [CNT_BITS-1:0] STOP_HI_C = CNT_BITS'(STOP_HI);
  localparam logic [CNT_BITS-1:0] CCW_LO_C  = CNT_BITS'(CCW_LO);
  localparam logic [CNT_BITS-1:0] CCW_HI_C  = CNT_BITS'(CCW_HI);
  localparam logic [CNT_BITS-1:0] PER_LO_C  = CNT_BITS'(PER_LO);
  localparam logic [CNT_BITS-1:0] PER_HI_C  = CNT_BITS'(PER_HI);

  state_t              state, state_n;
  logic                sync_meta, sync_q, prev;
  logic [CNT_BITS-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_BITS-1:0] hi_cnt, hi_cnt_n;
  logic [CNT_BITS-1:0] on_time_n, period_n;
  logic [1:0]          dir_n;
  logic                valid_n, lost_n;
  logic                rise, fall, timeout;

  // Period gate first, then the first matching width window wins.
  function automatic logic [1:0] decode(input logic [CNT_BITS-1:0] hi,
                                        input logic [CNT_BITS-1:0] per);
    logic [1:0] code;
    code = DIR_INVALID;
    if (per >= PER_LO_C && per <= PER_HI_C) begin
      if (hi >= CW_LO_C && hi <= CW_HI_C)
        code = DIR_CW;
      else if (hi >= STOP_LO_C && hi <= STOP_HI_C)
        code = DIR_STOP;
      else if (hi >= CCW_LO_C && hi <= CCW_HI_C)
        code = DIR_CCW;
    end
    return code;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= in;
      sync_q    <= sync_meta;
    end
  end

  assign rise    = clk_en & sync_q & ~prev;
  assign fall    = clk_en & ~sync_q & prev;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign timeout = clk_en & (cnt_inc == TIMEOUT_C);

  // A timeout overrides any edge seen on the same tick, including a frame start in IDLE.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_cnt_n  = hi_cnt;
    on_time_n = on_time;
    period_n  = period;
    dir_n     = dir;
    lost_n    = lost;
    valid_n   = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      cnt_n   = '0;
      lost_n  = 1'b1;
      dir_n   = DIR_INVALID;
    end else if (clk_en) begin
      cnt_n = rise ? CNT_ONE : cnt_inc;
      case (state)
        IDLE: if (rise) state_n = HIGH;
        HIGH: if (fall) begin
          hi_cnt_n = cnt;
          state_n  = LOW;
        end
        LOW: if (rise) begin
          on_time_n = hi_cnt;
          period_n  = cnt;
          dir_n     = decode(hi_cnt, cnt);
          lost_n    = 1'b0;
          valid_n   = 1'b1;
          state_n   = HIGH;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      prev    <= 1'b0;
      hi_cnt  <= '0;
      on_time <= '0;
      period  <= '0;
      dir     <= DIR_INVALID;
      valid   <= 1'b0;
      lost    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      if (clk_en) prev <= sync_q;
      hi_cnt  <= hi_cnt_n;
      on_time <= on_time_n;
      period  <= period_n;
      dir     <= dir_n;
      valid   <= valid_n;
      lost    <= lost_n;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder: streams PWM frames into the decoder and
// compares every valid pulse with results computed from the frame list.
`timescale 1ns/1ps
module tb_servo_pwm_decoder;

  typedef struct packed {
    logic [1:0]  dir;
    logic [15:0] on_time;
    logic [15:0] period;
  } res_t;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        clk_en = 1'b1;
  logic        in     = 1'b0;
  logic [1:0]  dir;
  logic [15:0] on_time;
  logic [15:0] period;
  logic        valid;
  logic        lost;

  int   checks       = 0;
  int   errors       = 0;
  int   en_div       = 1;
  int   en_phase     = 0;
  int   double_valid = 0;
  logic valid_prev   = 1'b0;
  res_t exp_q[$];
  res_t obs_q[$];

  servo_pwm_decoder dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .in      (in),
    .dir     (dir),
    .on_time (on_time),
    .period  (period),
    .valid   (valid),
    .lost    (lost)
  );

  always #5 clk = ~clk;

  // One tick every en_div clocks, changed away from the active edge.
  always @(negedge clk) begin
    en_phase = (en_phase + 1 >= en_div) ? 0 : en_phase + 1;
    clk_en   = (en_phase == 0);
  end

  // Record every valid pulse and any pulse that lasts longer than one clock.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      obs_q.push_back({dir, on_time, period});
      if (valid_prev === 1'b1) double_valid++;
    end
    valid_prev = valid;
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [1:0] model_dir(input int h, input int p);
    if (p < 1900 || p > 2100) return 2'b11;
    if (h >= 90 && h <= 110) return 2'b01;
    if (h >= 140 && h <= 160) return 2'b00;
    if (h >= 190 && h <= 210) return 2'b10;
    return 2'b11;
  endfunction

  task automatic wait_tick();
    @(posedge clk);
    while (clk_en !== 1'b1) @(posedge clk);
  endtask

  // One frame: high for h ticks, low for l ticks; its result is due at the next rising edge.
  task automatic drive_frame(input int h, input int l, input bit glitch = 1'b0);
    exp_q.push_back({model_dir(h, h + l), 16'(h), 16'(h + l)});
    in = 1'b1;
    repeat (h) wait_tick();
    @(negedge clk);
    in = 1'b0;
    if (glitch) begin
      repeat (l / 2) wait_tick();
      repeat (3) @(negedge clk);
      in = 1'b1;
      @(negedge clk);
      in = 1'b0;
      repeat (l - l / 2) wait_tick();
    end else begin
      repeat (l) wait_tick();
    end
    @(negedge clk);
  endtask

  task automatic close_stream();
    in = 1'b1;
    repeat (20) wait_tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    double_valid = 0;
    wait_tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in    = 1'b0;
    repeat (3) @(negedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        reset = 1'b0;
        repeat (5) @(negedge clk);
      end
      checks++; if (dir !== 2'b11) begin errors++; $display("[TB] FAIL reset_dir phase %0d got %b want 11", ph, dir); end
      checks++; if (on_time !== 16'd0) begin errors++; $display("[TB] FAIL reset_on_time phase %0d got %0d want 0", ph, on_time); end
      checks++; if (period !== 16'd0) begin errors++; $display("[TB] FAIL reset_period phase %0d got %0d want 0", ph, period); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid phase %0d got %b want 0", ph, valid); end
      checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL reset_lost phase %0d got %b want 0", ph, lost); end
    end
  endtask

  task automatic test_cw_frames();
    apply_reset();
    repeat (3) drive_frame(100, 1900);
    close_stream();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL cw_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL cw_frame %0d got dir=%b on=%0d per=%0d want dir=%b on=%0d per=%0d", i, obs_q[i].dir, obs_q[i].on_time, obs_q[i].period, exp_q[i].dir, exp_q[i].on_time, exp_q[i].period); end
    end
    checks++;
    if (double_valid != 0) begin errors++; $display("[TB] FAIL cw_valid_width got %0d long pulses want 0", double_valid); end
  endtask

  task automatic test_decode_windows();
    int hs[9] = '{150, 200, 125, 150, 90, 210, 89, 160, 140};
    int ls[9] = '{1850, 1800, 1875, 1500, 1810, 1890, 1811, 1739, 1961};
    apply_reset();
    foreach (hs[i]) drive_frame(hs[i], ls[i]);
    close_stream();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL decode_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL decode_frame %0d got dir=%b on=%0d per=%0d want dir=%b on=%0d per=%0d", i, obs_q[i].dir, obs_q[i].on_time, obs_q[i].period, exp_q[i].dir, exp_q[i].on_time, exp_q[i].period); end
    end
  endtask

  task automatic test_random_frames();
    int h;
    int p;
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      h = int'($urandom_range(220, 80));
      p = int'($urandom_range(2120, 1880));
      drive_frame(h, p - h);
    end
    close_stream();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL random_frame %0d got dir=%b on=%0d per=%0d want dir=%b on=%0d per=%0d", i, obs_q[i].dir, obs_q[i].on_time, obs_q[i].period, exp_q[i].dir, exp_q[i].on_time, exp_q[i].period); end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    repeat (2) drive_frame(150, 1850);
    in = 1'b1;
    repeat (3900) wait_tick();
    @(negedge clk);
    checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_lost got %b want 0", lost); end
    checks++; if (dir !== 2'b00) begin errors++; $display("[TB] FAIL timeout_early_dir got %b want 00", dir); end
    repeat (200) wait_tick();
    @(negedge clk);
    checks++; if (lost !== 1'b1) begin errors++; $display("[TB] FAIL timeout_lost got %b want 1", lost); end
    checks++; if (dir !== 2'b11) begin errors++; $display("[TB] FAIL timeout_dir got %b want 11", dir); end
    checks++; if (obs_q.size() != 2) begin errors++; $display("[TB] FAIL timeout_no_valid got %0d pulses want 2", obs_q.size()); end
    repeat (900) wait_tick();
    @(negedge clk);
    in = 1'b0;
    repeat (500) wait_tick();
    @(negedge clk);
    drive_frame(150, 1850);
    checks++; if (lost !== 1'b1) begin errors++; $display("[TB] FAIL resume_first_edge_lost got %b want 1", lost); end
    drive_frame(150, 1850);
    checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL resume_lost got %b want 0", lost); end
    close_stream();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL timeout_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL timeout_frame %0d got dir=%b on=%0d per=%0d want dir=%b on=%0d per=%0d", i, obs_q[i].dir, obs_q[i].on_time, obs_q[i].period, exp_q[i].dir, exp_q[i].on_time, exp_q[i].period); end
    end
  endtask

  task automatic test_clk_en_scaled();
    en_div = 4;
    apply_reset();
    drive_frame(100, 1900);
    drive_frame(100, 1900, 1'b1);
    drive_frame(100, 1900);
    close_stream();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL scaled_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL scaled_frame %0d got dir=%b on=%0d per=%0d want dir=%b on=%0d per=%0d", i, obs_q[i].dir, obs_q[i].on_time, obs_q[i].period, exp_q[i].dir, exp_q[i].on_time, exp_q[i].period); end
    end
    checks++;
    if (double_valid != 0) begin errors++; $display("[TB] FAIL scaled_valid_width got %0d long pulses want 0", double_valid); end
    en_div = 1;
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    drive_frame(150, 1850);
    in = 1'b1;
    repeat (60) wait_tick();
    @(negedge clk);
    checks++; if (on_time !== 16'd150) begin errors++; $display("[TB] FAIL midreset_before_on got %0d want 150", on_time); end
    reset = 1'b1;
    #1;
    checks++; if (dir !== 2'b11) begin errors++; $display("[TB] FAIL midreset_dir got %b want 11", dir); end
    checks++; if (on_time !== 16'd0) begin errors++; $display("[TB] FAIL midreset_on_time got %0d want 0", on_time); end
    checks++; if (period !== 16'd0) begin errors++; $display("[TB] FAIL midreset_period got %0d want 0", period); end
    checks++; if (valid !== 1'b0 || lost !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags got valid=%b lost=%b want 0 0", valid, lost); end
    repeat (90) wait_tick();
    @(negedge clk);
    in = 1'b0;
    repeat (100) wait_tick();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    repeat (1750) wait_tick();
    @(negedge clk);
    drive_frame(150, 1850);
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL midreset_first_edge got %0d pulses want 0", obs_q.size()); end
    drive_frame(150, 1850);
    close_stream();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL midreset_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL midreset_frame %0d got dir=%b on=%0d per=%0d want dir=%b on=%0d per=%0d", i, obs_q[i].dir, obs_q[i].on_time, obs_q[i].period, exp_q[i].dir, exp_q[i].on_time, exp_q[i].period); end
    end
  endtask

  initial begin
    test_reset();
    test_cw_frames();
    test_decode_windows();
    test_random_frames();
    test_timeout();
    test_clk_en_scaled();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Receive-side counterpart of the servo controller's PWM output. The block measures an incoming servo PWM waveform (pulse high time and rising-to-rising period) in units of `clk_en` ticks, and decodes the pulse width into a servo direction code. It also reports loss of signal. It is used for loopback self-test of the plotter servo path and as a bench monitor for the servo PWM pin.

## Interface
- `CNT_BITS`, 16: width of the tick counter and of the `on_time` / `period` outputs.
- `CW_LO`, `CW_HI`, 90 / 110: inclusive `on_time` window decoded as CW.
- `STOP_LO`, `STOP_HI`, 140 / 160: inclusive `on_time` window decoded as STOP.
- `CCW_LO`, `CCW_HI`, 190 / 210: inclusive `on_time` window decoded as CCW.
- `PER_LO`, `PER_HI`, 1900 / 2100: inclusive valid-period window.
- `TIMEOUT`, 4000: ticks without a completed edge before the block declares signal lost.
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `clk_en` in 1: tick enable. All measurement advances only on ticks.
- `in` in 1: PWM input, asynchronous to `clk`.
- `dir` out 2: decoded direction. 2'b00 STOP, 2'b01 CW, 2'b10 CCW, 2'b11 INVALID.
- `on_time` out CNT_BITS: high time of the last completed frame, in ticks.
- `period` out CNT_BITS: period of the last completed frame, in ticks.
- `valid` out 1: one-`clk` pulse when `dir`, `on_time` and `period` update.
- `lost` out 1: level. Set on timeout, cleared on the next completed frame.

## Operation
- Synchronizer:
  - `in` passes through a 2-flop synchronizer clocked every `clk`, independent of `clk_en`.
  - A sample register `prev` captures the synchronized value on ticks only.
  - Edge detection compares the synchronized value with `prev`, on ticks only.
  - Pulses narrower than one tick may be missed; this is accepted behaviour.
- Counter `cnt`:
  - Saturates at 2^CNT_BITS-1 and never wraps.
  - On the tick where a rising edge is detected: `cnt` is set to 1.
  - On every other tick in HIGH, LOW or IDLE: `cnt` increments.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: a rising edge goes to HIGH. Any partial frame seen before the first rising edge is discarded.
  - HIGH: a falling edge latches `hi_cnt` <= `cnt` and goes to LOW.
  - LOW: a rising edge completes the frame and returns to HIGH with `cnt` = 1.
  - Timeout: if `cnt` reaches `TIMEOUT` in any state, go to IDLE with `lost` <= 1, `dir` <= INVALID, `cnt` <= 0, and no `valid` pulse. This covers stuck-high, stuck-low and absent input.
- Frame completion (rising edge in LOW):
  - `on_time` <= `hi_cnt`; `period` <= `cnt`; `lost` <= 0; `valid` pulses.
  - For a waveform high H ticks and low L ticks: `on_time` = H, `period` = H+L.
- Decode:
  - If `period` is outside [PER_LO, PER_HI], `dir` = INVALID.
  - Otherwise the first matching `on_time` window among CW, STOP, CCW gives `dir`.
  - No matching window gives INVALID.
  - An INVALID frame still pulses `valid`.
- Simultaneous events:
  - A timeout and an edge on the same tick: the timeout wins.
  - A rising edge detected in IDLE on the tick `cnt` reaches `TIMEOUT`: the timeout wins; the block stays in IDLE with `cnt` = 0, and the next rising edge starts a frame.
- `clk_en` low: FSM, counter, `prev` and outputs hold. `valid` is never raised.

## Timing
- Reset values:
  - State IDLE; `cnt` 0; `prev` 0; synchronizer 0.
  - `dir` 2'b11; `on_time` 0; `period` 0; `valid` 0; `lost` 0.
- Reset asserted mid-frame: immediate return to the reset values. The next frame starts only at a rising edge seen in IDLE.
- Outputs are registered.
  - `valid` is high for exactly the one `clk` cycle following the tick that detected the completing rising edge, even if `clk_en` is held high.
  - `dir`, `on_time` and `period` change in that same cycle and hold until the next completion or timeout.
- Latency from a pin rising edge to `valid`: 2 `clk` of synchronizer, plus up to one tick interval of edge alignment, plus 1 `clk`.
- `lost` rises one `clk` after the timeout tick.
- First `valid` after reset or loss: at the second rising edge, one full frame later.

## Test plan
- With `clk_en`=1 every cycle, drive 100-high/1900-low frames x3: `valid` pulses once per frame starting at the second rising edge, with `dir`=01, `on_time`=100, `period`=2000.
- Frames of 150/1850 then 200/1800: `dir`=00 with `on_time`=150, then `dir`=10 with `on_time`=200; `period`=2000 throughout.
- Frame of 125/1875 (gap between windows) and a frame of 150/1500 (period 1650): each gives `valid` with `dir`=11.
- Hold `in` high for 5000 ticks after one rising edge: `lost`=1 and `dir`=11 at tick 4000 with no `valid`. Resume 150/1850 frames: `lost`=0 and `dir`=00 at the second new rising edge.
- `clk_en` asserted 1 cycle in 4 with the waveform scaled x4 in `clk` cycles: results identical to the first scenario. A 1-`clk` glitch on `in` between ticks is ignored.
- Assert `reset` mid-HIGH of a 150/1850 stream: all outputs return to reset values immediately, and the first `valid` appears at the second rising edge after reset release.
